// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, funct3 codes and request legality helpers
package mem_resp_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_LATCH, S_WAIT, S_RESP, S_DONE} state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return (f3[1:0] == F3_H[1:0] && off[0]) || (f3[1:0] == F3_W[1:0] && off != 2'b00);
   endfunction
   function automatic logic bad_load(input logic [2:0] f3);
      return f3 == 3'b011 || f3[2:1] == 2'b11;
   endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: core request/response bus plus the SRAM port of the responder
interface mem_responder_if #(parameter int AW = 14);
   logic [31:0]   mem_addr;
   logic          mem_read;
   logic          mem_write;
   logic [3:0]    mem_wrbits;
   logic [2:0]    mem_funct3;
   logic [31:0]   mem_wrdata;
   logic [31:0]   mem_rddata;
   logic          mem_ready;
   logic          mem_err;
   logic [AW-1:0] ram_addr;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   modport slave (
      input  mem_addr, mem_read, mem_write, mem_wrbits, mem_funct3, mem_wrdata, ram_rdata,
      output mem_rddata, mem_ready, mem_err, ram_addr, ram_en, ram_we, ram_wdata
   );
   modport master (
      output mem_addr, mem_read, mem_write, mem_wrbits, mem_funct3, mem_wrdata, ram_rdata,
      input  mem_rddata, mem_ready, mem_err, ram_addr, ram_en, ram_we, ram_wdata
   );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half of a RAM word and sign/zero-extends it
module mem_load_align
   import mem_resp_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_f3,
   output logic [31:0] o_data
);
   logic [7:0]  w_b;
   logic [15:0] w_h;
   assign w_b = 8'(i_word >> {i_off, 3'b000});
   assign w_h = i_off[1] ? i_word[31:16] : i_word[15:0];
   // funct3[2] marks the unsigned variants, so it suppresses sign replication
   assign o_data = i_f3[1:0] == F3_B[1:0] ? {{24{w_b[7] & ~i_f3[2]}}, w_b} :
                   i_f3[1:0] == F3_H[1:0] ? {{16{w_h[15] & ~i_f3[2]}}, w_h} : i_word;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: data-memory responder driving a 1-cycle-latency SRAM with optional wait states
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int AW          = 14,
   parameter int WAIT_CYCLES = 0
)(
   input logic          clock,
   input logic          reset,
   mem_responder_if.slave bus
);
   state_t        r_state, w_next;
   logic [1:0]    r_off;
   logic [2:0]    r_f3;
   logic          r_wr;
   logic [3:0]    r_cnt;
   logic          r_ready, r_err, r_ram_en;
   logic [3:0]    r_ram_we;
   logic [AW-1:0] r_ram_addr;
   logic [31:0]   r_ram_wdata, r_rddata;
   logic          w_req, w_err;
   logic [31:0]   w_wdata, w_ld;
   assign w_req = bus.mem_read | bus.mem_write;
   assign w_err = (bus.mem_read & bus.mem_write) | misaligned(bus.mem_funct3, bus.mem_addr[1:0]) |
                  ((bus.mem_addr >> (AW + 2)) != 32'd0) | (bus.mem_read & bad_load(bus.mem_funct3));
   assign w_wdata = bus.mem_funct3[1:0] == F3_B[1:0] ? bus.mem_wrdata << {bus.mem_addr[1:0], 3'b000} :
                    bus.mem_funct3[1:0] == F3_H[1:0] ? bus.mem_wrdata << {bus.mem_addr[1], 4'b0000} :
                    bus.mem_wrdata;
   mem_load_align u_align (
      .i_word (bus.ram_rdata),
      .i_off  (r_off),
      .i_f3   (r_f3),
      .o_data (w_ld)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_req) w_next = w_err ? S_RESP : S_ACCESS;
         S_ACCESS: w_next = !r_wr ? S_LATCH : (WAIT_CYCLES > 0 ? S_WAIT : S_RESP);
         S_LATCH:  w_next = WAIT_CYCLES > 0 ? S_WAIT : S_RESP;
         S_WAIT:   if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP:   w_next = S_DONE;
         S_DONE:   if (!w_req) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the state they belong to
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_off       <= '0;
         r_f3        <= '0;
         r_wr        <= 1'b0;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_err       <= 1'b0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= '0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_rddata    <= '0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= r_state == S_WAIT ? r_cnt - 4'd1 : 4'(WAIT_CYCLES - 1);
         r_ready  <= w_next == S_RESP;
         r_err    <= w_next == S_RESP && r_state == S_IDLE;
         r_ram_en <= w_next == S_ACCESS;
         r_ram_we <= (w_next == S_ACCESS && bus.mem_write) ? bus.mem_wrbits : 4'b0000;
         if (r_state == S_IDLE && w_req) begin
            r_off <= bus.mem_addr[1:0];
            r_f3  <= bus.mem_funct3;
            r_wr  <= bus.mem_write;
         end
         if (w_next == S_ACCESS) begin
            r_ram_addr  <= bus.mem_addr[AW+1:2];
            r_ram_wdata <= w_wdata;
         end
         if (r_state == S_LATCH) r_rddata <= w_ld;
      end
   end
   assign bus.mem_rddata = r_rddata;
   assign bus.mem_ready  = r_ready;
   assign bus.mem_err    = r_err;
   assign bus.ram_addr   = r_ram_addr;
   assign bus.ram_en     = r_ram_en;
   assign bus.ram_we     = r_ram_we;
   assign bus.ram_wdata  = r_ram_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench with behavioural SRAMs for WAIT_CYCLES=0 and WAIT_CYCLES=3 instances
module tb_mem_responder;
   import mem_resp_pkg::*;
   localparam int AW = 14;
   typedef struct {int t; logic [31:0] d; logic e;} resp_t;
   typedef struct {logic [AW-1:0] a; logic [3:0] we; logic [31:0] wd;} ram_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int rdy3 = 0;
   int en3 = 0;
   resp_t q0[$], q3[$];
   ram_t qr0[$];
   logic [31:0] mem0[0:255], mem3[0:255];
   logic [31:0] rd0, rd3;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   mem_responder_if #(.AW(AW)) b0();
   mem_responder_if #(.AW(AW)) b3();
   mem_responder #(.AW(AW), .WAIT_CYCLES(0)) dut0 (.clock(clk), .reset(reset), .bus(b0));
   mem_responder #(.AW(AW), .WAIT_CYCLES(3)) dut3 (.clock(clk), .reset(reset), .bus(b3));
   assign b0.ram_rdata = rd0;
   assign b3.ram_rdata = rd3;
   always @(posedge clk) begin
      if (b0.ram_en) begin
         rd0 <= mem0[b0.ram_addr[7:0]];
         for (int i = 0; i < 4; i++) if (b0.ram_we[i]) mem0[b0.ram_addr[7:0]][8*i +: 8] <= b0.ram_wdata[8*i +: 8];
      end
      if (b3.ram_en) rd3 <= mem3[b3.ram_addr[7:0]];
   end
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask
   always @(negedge clk) begin
      resp_t r;
      ram_t m;
      if (b0.mem_ready === 1'b1) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: got ready=1 want no ready");
         end else begin
            r = q0.pop_front();
            chk("ready_cycle", cyc, r.t);
            chk("mem_err", {31'b0, b0.mem_err}, {31'b0, r.e});
            chk("mem_rddata", b0.mem_rddata, r.d);
         end
      end
      if (b0.ram_en === 1'b1) begin
         if (qr0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ram_en: got ram_en=1 want 0");
         end else begin
            m = qr0.pop_front();
            chk("ram_addr", 32'(b0.ram_addr), 32'(m.a));
            chk("ram_we", 32'(b0.ram_we), 32'(m.we));
            if (m.we != 4'b0000) chk("ram_wdata", b0.ram_wdata, m.wd);
         end
      end
      if (b3.mem_ready === 1'b1) begin
         rdy3++;
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready3: got ready=1 want no ready");
         end else begin
            r = q3.pop_front();
            chk("ready_cycle3", cyc, r.t);
            chk("mem_err3", {31'b0, b3.mem_err}, {31'b0, r.e});
            chk("mem_rddata3", b3.mem_rddata, r.d);
         end
      end
      if (b3.ram_en === 1'b1) en3++;
   end
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3,
                         input logic [3:0] wb, input logic [31:0] wd, input logic [31:0] exp_d,
                         input logic exp_e, input int lat, input logic [3:0] exp_we, input logic [31:0] exp_wd);
      logic got;
      if (!exp_e) qr0.push_back('{a[AW+1:2], exp_we, exp_wd});
      @(posedge clk);
      #1;
      b0.mem_read = rd;
      b0.mem_write = wr;
      b0.mem_addr = a;
      b0.mem_funct3 = f3;
      b0.mem_wrbits = wb;
      b0.mem_wrdata = wd;
      q0.push_back('{cyc + lat, exp_d, exp_e});
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk);
         got = b0.mem_ready;
      end
      if (!got) chk("ready_timeout", {31'b0, got}, 32'd1);
      @(posedge clk);
      #1;
      b0.mem_read = 1'b0;
      b0.mem_write = 1'b0;
      @(posedge clk);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem0[i] = '0;
         mem3[i] = '0;
      end
      mem3[5] = 32'hCAFEF00D;
      {b0.mem_read, b0.mem_write, b0.mem_addr, b0.mem_funct3, b0.mem_wrbits, b0.mem_wrdata} = '0;
      {b3.mem_read, b3.mem_write, b3.mem_addr, b3.mem_funct3, b3.mem_wrbits, b3.mem_wrdata} = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'b0, b0.mem_ready}, 32'd0);
      chk("rst_ram_en", {31'b0, b0.ram_en}, 32'd0);
      chk("rst_rddata", b0.mem_rddata, 32'd0);
      chk("rst_state", 32'(dut0.r_state), 32'(S_IDLE));
      do_req(0, 1, 32'h10, F3_W, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 2, 4'b1111, 32'hDEADBEEF);
      do_req(1, 0, 32'h10, F3_W, 4'b0000, 32'h0, 32'hDEADBEEF, 0, 3, 4'b0000, 32'h0);
      do_req(0, 1, 32'h13, F3_B, 4'b1000, 32'h80, 32'hDEADBEEF, 0, 2, 4'b1000, 32'h80000000);
      do_req(1, 0, 32'h13, F3_B, 4'b0000, 32'h0, 32'hFFFFFF80, 0, 3, 4'b0000, 32'h0);
      do_req(1, 0, 32'h13, F3_BU, 4'b0000, 32'h0, 32'h00000080, 0, 3, 4'b0000, 32'h0);
      do_req(0, 1, 32'h22, F3_H, 4'b1100, 32'h1234, 32'h00000080, 0, 2, 4'b1100, 32'h12340000);
      do_req(1, 0, 32'h22, F3_H, 4'b0000, 32'h0, 32'h00001234, 0, 3, 4'b0000, 32'h0);
      do_req(1, 0, 32'h21, F3_W, 4'b0000, 32'h0, 32'h00001234, 1, 1, 4'b0000, 32'h0);
      do_req(1, 1, 32'h10, F3_W, 4'b1111, 32'h1, 32'h00001234, 1, 1, 4'b0000, 32'h0);
      do_req(1, 0, 32'h00010000, F3_W, 4'b0000, 32'h0, 32'h00001234, 1, 1, 4'b0000, 32'h0);
      do_req(1, 0, 32'h10, 3'b011, 4'b0000, 32'h0, 32'h00001234, 1, 1, 4'b0000, 32'h0);
      do_req(0, 1, 32'h26, F3_H, 4'b1100, 32'hFFFF8001, 32'h00001234, 0, 2, 4'b1100, 32'h80010000);
      do_req(1, 0, 32'h26, F3_H, 4'b0000, 32'h0, 32'hFFFF8001, 0, 3, 4'b0000, 32'h0);
      do_req(1, 0, 32'h26, F3_HU, 4'b0000, 32'h0, 32'h00008001, 0, 3, 4'b0000, 32'h0);
      do_req(1, 0, 32'h11, F3_B, 4'b0000, 32'h0, 32'hFFFFFFBE, 0, 3, 4'b0000, 32'h0);
      @(posedge clk);
      #1;
      b3.mem_read = 1'b1;
      b3.mem_addr = 32'h14;
      b3.mem_funct3 = F3_W;
      q3.push_back('{cyc + 6, 32'hCAFEF00D, 1'b0});
      repeat (10) @(posedge clk);
      #1;
      b3.mem_read = 1'b0;
      repeat (4) @(negedge clk);
      chk("held_ready_count", rdy3, 1);
      chk("held_ram_en_count", en3, 1);
      chk("held_q_empty", q3.size(), 0);
      qr0.push_back('{14'd12, 4'b1111, 32'h55});
      @(posedge clk);
      #1;
      b0.mem_write = 1'b1;
      b0.mem_addr = 32'h30;
      b0.mem_funct3 = F3_W;
      b0.mem_wrbits = 4'b1111;
      b0.mem_wrdata = 32'h55;
      @(posedge clk);
      #1;
      chk("mid_state", 32'(dut0.r_state), 32'(S_ACCESS));
      reset = 1'b1;
      b0.mem_write = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", 32'(dut0.r_state), 32'(S_IDLE));
      chk("mid_rst_ready", {31'b0, b0.mem_ready}, 32'd0);
      chk("mid_rst_err", {31'b0, b0.mem_err}, 32'd0);
      chk("mid_rst_ram_en", {31'b0, b0.ram_en}, 32'd0);
      chk("mid_rst_ram_we", 32'(b0.ram_we), 32'd0);
      chk("mid_rst_ram_addr", 32'(b0.ram_addr), 32'd0);
      chk("mid_rst_ram_wdata", b0.ram_wdata, 32'd0);
      chk("mid_rst_rddata", b0.mem_rddata, 32'd0);
      repeat (5) @(negedge clk);
      chk("resp_q_empty", q0.size(), 0);
      chk("ram_q_empty", qr0.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
